// File: rtl/gradient_batch_framer.sv
// Frames gradient batches: parses N from the header beat, forwards ceil((N+1)/EPL) lines
// through one registered AXI-Stream stage, and tags the final line with TLAST and a tail keep.
module gradient_batch_framer #(
  parameter int DATA_W   = 512,
  parameter int ELEM_W   = 32,
  parameter int ZERO_HDR = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data_TDATA,
  input  logic              rx_data_TVALID,
  output logic              rx_data_TREADY,
  output logic [DATA_W-1:0] tx_data_TDATA,
  output logic              tx_data_TVALID,
  input  logic              tx_data_TREADY,
  output logic              tx_data_TLAST,
  output logic [DATA_W/ELEM_W-1:0] tx_data_TKEEP,
  output logic [31:0]       N,
  output logic              batch_ending,
  output logic [CNT_W-1:0]  batch_count
);
  localparam int EPL      = DATA_W / ELEM_W;
  localparam int LOG2_EPL = $clog2(EPL);
  localparam logic [EPL-1:0] KEEP_ONE = {{(EPL-1){1'b0}}, 1'b1};
  localparam logic [31:0] N_MASK =
    (ELEM_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ELEM_W) - 64'd1);

  typedef enum logic {HDR, BODY} state_t;

  state_t            state_q, state_d;
  logic [32:0]       remaining_q, remaining_d;
  logic [EPL-1:0]    tail_keep_q, tail_keep_d;
  logic [31:0]       n_q, n_d;
  logic              tvalid_q;
  logic [DATA_W-1:0] tdata_q;
  logic [EPL-1:0]    tkeep_q;
  logic              tlast_q;
  logic              end_q;
  logic [CNT_W-1:0]  count_q;

  logic              rx_hs, tx_hs;
  logic [31:0]       hdr_n;
  logic [32:0]       hdr_np1, hdr_lines;
  logic [EPL-1:0]    hdr_keep;
  logic [DATA_W-1:0] beat_data;
  logic [EPL-1:0]    beat_keep;
  logic              beat_last;

  // Keep mask for the last line; a zero tail means the last line is full.
  function automatic logic [EPL-1:0] tail_keep(input logic [32:0] np1);
    logic [LOG2_EPL-1:0] tail;
    tail = np1[LOG2_EPL-1:0];
    if (tail == '0) return '1;
    return (KEEP_ONE << tail) - KEEP_ONE;
  endfunction

  assign rx_data_TREADY = !tvalid_q || tx_data_TREADY;
  assign rx_hs          = rx_data_TVALID && rx_data_TREADY;
  assign tx_hs          = tvalid_q && tx_data_TREADY;

  // 33-bit slot count so N=0xFFFFFFFF still yields a correct line count.
  assign hdr_n     = rx_data_TDATA[31:0] & N_MASK;
  assign hdr_np1   = {1'b0, hdr_n} + 33'd1;
  assign hdr_lines = (hdr_np1 + 33'(EPL - 1)) >> LOG2_EPL;
  assign hdr_keep  = tail_keep(hdr_np1);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tail_keep_d = tail_keep_q;
    n_d         = n_q;
    beat_data   = rx_data_TDATA;
    beat_keep   = '1;
    beat_last   = 1'b0;
    case (state_q)
      HDR: begin
        if (rx_hs) begin
          n_d         = hdr_n;
          remaining_d = hdr_lines - 33'd1;
          tail_keep_d = hdr_keep;
          if (ZERO_HDR != 0) beat_data[ELEM_W-1:0] = '0;
          if (hdr_lines == 33'd1) begin
            beat_last = 1'b1;
            beat_keep = hdr_keep;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (rx_hs) begin
          remaining_d = remaining_q - 33'd1;
          if (remaining_q == 33'd1) begin
            beat_last = 1'b1;
            beat_keep = tail_keep_q;
            state_d   = HDR;
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      remaining_q <= '0;
      tail_keep_q <= '0;
      n_q         <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      end_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tail_keep_q <= tail_keep_d;
      n_q         <= n_d;
      // A new beat overwrites the register in the same cycle the old one leaves.
      if (rx_hs) begin
        tvalid_q <= 1'b1;
        tdata_q  <= beat_data;
        tkeep_q  <= beat_keep;
        tlast_q  <= beat_last;
      end else if (tx_data_TREADY) begin
        tvalid_q <= 1'b0;
      end
      end_q <= tx_hs && tlast_q;
      if (tx_hs && tlast_q) count_q <= count_q + CNT_W'(1);
    end
  end

  assign tx_data_TDATA  = tdata_q;
  assign tx_data_TVALID = tvalid_q;
  assign tx_data_TKEEP  = tkeep_q;
  assign tx_data_TLAST  = tlast_q;
  assign N              = n_q;
  assign batch_ending   = end_q;
  assign batch_count    = count_q;
endmodule
